tf_fetch_sched: RTL and testbench

Sequencer for the horizontal twiddle-factor ROMs of the radix-16 NTT datapath. It steps the butterfly array through all stages, groups and beats of one transform. It drives the shared `stage_counter`, the active-low ROM enable `cen` and the twiddle index, and flags when ROM output data is valid. A `start`/`done` handshake connects it to the top-level FFT controller, and a `ready` input lets downstream logic stall the fetch stream.

---
 rtl/tf_fetch_sched.sv | 99 +++++++++
 tb/tb_tf_fetch_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tf_fetch_sched.sv
// tf_fetch_sched: steps stage/group/beat counters for the twiddle ROMs, drives cen, tf_idx and tf_valid
module tf_fetch_sched #(
   parameter int SC_WIDTH         = 3,
   parameter int NUM_STAGES       = 4,
   parameter int BEAT_WIDTH       = 4,
   parameter int IDX_WIDTH        = 6,
   parameter int GROUPS_PER_STAGE = 64,
   parameter int START_IDX        = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  ready,
   output logic                  cen,
   output logic [SC_WIDTH-1:0]   stage_counter,
   output logic [IDX_WIDTH-1:0]  tf_idx,
   output logic [BEAT_WIDTH-1:0] beat,
   output logic                  tf_valid,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [BEAT_WIDTH-1:0] BEAT_LAST = '1;
   localparam logic [IDX_WIDTH-1:0]  GRP_LAST  = IDX_WIDTH'(GROUPS_PER_STAGE - 1);
   localparam logic [SC_WIDTH-1:0]   STG_LAST  = SC_WIDTH'(NUM_STAGES - 1);
   localparam logic [IDX_WIDTH-1:0]  IDX0      = IDX_WIDTH'(START_IDX);
   state_t                state, state_n;
   logic [IDX_WIDTH-1:0]  group, group_n, idx_n;
   logic [SC_WIDTH-1:0]   sc_n;
   logic [BEAT_WIDTH-1:0] beat_n;
   logic                  issue, clr;
   assign issue = (state == RUN) && ready;
   assign cen   = ~issue;
   always_comb begin
      state_n = state;
      sc_n    = stage_counter;
      group_n = group;
      beat_n  = beat;
      idx_n   = tf_idx;
      clr     = 1'b0;
      if (abort && state != IDLE) begin
         state_n = IDLE;
         clr     = 1'b1;
      end else begin
         case (state)
            IDLE: if (start && !abort) begin
               state_n = RUN;
               clr     = 1'b1;
            end
            RUN: if (issue) begin
               beat_n = beat + 1'b1;
               if (beat == BEAT_LAST) begin
                  group_n = group + 1'b1;
                  idx_n   = tf_idx + 1'b1;
                  if (group == GRP_LAST) begin
                     group_n = '0;
                     idx_n   = IDX0;
                     sc_n    = stage_counter + 1'b1;
                     // final beat of the transform: park counters for the next run
                     if (stage_counter == STG_LAST) begin
                        state_n = DRAIN;
                        clr     = 1'b1;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (clr) begin
         sc_n    = '0;
         group_n = '0;
         beat_n  = '0;
         idx_n   = IDX0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         stage_counter <= '0;
         group         <= '0;
         beat          <= '0;
         tf_idx        <= IDX0;
         tf_valid      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         stage_counter <= sc_n;
         group         <= group_n;
         beat          <= beat_n;
         tf_idx        <= idx_n;
         tf_valid      <= issue;
         busy          <= state_n != IDLE;
         done          <= state_n == DRAIN;
      end
   end
endmodule

// File: tb/tb_tf_fetch_sched.sv
// tb_tf_fetch_sched: vector table plus beat scoreboard for tf_fetch_sched (2x2 config and 1-stage wrap config)
module tb_tf_fetch_sched;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, ready = 1'b1;
   logic cen, tf_valid, busy, done;
   logic [2:0] sc;
   logic [5:0] tf_idx;
   logic [3:0] beat;
   logic start_w = 1'b0, abort_w = 1'b0, ready_w = 1'b1;
   logic cen_w, valid_w, busy_w, done_w;
   logic [2:0] sc_w;
   logic [5:0] idx_w;
   logic [3:0] beat_w;

   tf_fetch_sched #(.NUM_STAGES(2), .GROUPS_PER_STAGE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
      .cen(cen), .stage_counter(sc), .tf_idx(tf_idx), .beat(beat),
      .tf_valid(tf_valid), .busy(busy), .done(done));

   tf_fetch_sched #(.NUM_STAGES(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort_w), .ready(ready_w),
      .cen(cen_w), .stage_counter(sc_w), .tf_idx(idx_w), .beat(beat_w),
      .tf_valid(valid_w), .busy(busy_w), .done(done_w));

   always #5 clk = ~clk;

   typedef struct packed {logic [2:0] sc; logic [5:0] idx; logic [3:0] beat;} beat_t;
   typedef struct {logic start; logic abort; logic ready; logic [16:0] exp;} vec_t;

   int n_chk = 0, n_pass = 0;
   beat_t q[$], qw[$];
   bit sb_on = 0, sbw_on = 0, prev_iss = 0, prev_w = 0;
   int cyc = 0, n_iss = 0, n_valid = 0, n_done = 0, last_iss = 0, done_cyc = 0, run_len = 0, max_run = 0;
   int cyc_w = 0, nw_iss = 0, nw_done = 0, last_w = 0, done_w_cyc = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [16:0] o(input bit c, b, d, v, input int s, i, bt);
      return {c, b, d, v, 3'(s), 6'(i), 4'(bt)};
   endfunction

   function automatic logic [16:0] cur();
      return {cen, busy, done, tf_valid, sc, tf_idx, beat};
   endfunction

   // reference ordering: 16 beats per group, gps groups per stage, index 1+group modulo 64
   function automatic beat_t model(input int n, input int gps);
      int g = n / 16;
      return {3'(g / gps), 6'((1 + g % gps) % 64), 4'(n % 16)};
   endfunction

   initial forever begin
      @(negedge clk);
      if (sb_on) begin
         cyc++;
         check("tf_valid_follows_cen", int'(tf_valid), int'(prev_iss));
         if (tf_valid) n_valid++;
         if (!cen) begin
            n_iss++;
            last_iss = cyc;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (q.size() == 0) check("extra_beat", n_iss, 0);
            else check("beat_outputs", int'({sc, tf_idx, beat}), int'(q.pop_front()));
         end else run_len = 0;
         if (done) begin
            n_done++;
            done_cyc = cyc;
            check("drain_cen_busy_valid", int'({cen, busy, tf_valid}), 7);
         end
         prev_iss = !cen;
      end
   end

   initial forever begin
      @(negedge clk);
      if (sbw_on) begin
         cyc_w++;
         check("wrap_valid_follows_cen", int'(valid_w), int'(prev_w));
         if (!cen_w) begin
            nw_iss++;
            last_w = cyc_w;
            if (qw.size() == 0) check("wrap_extra_beat", nw_iss, 0);
            else check("wrap_beat_outputs", int'({sc_w, idx_w, beat_w}), int'(qw.pop_front()));
         end
         if (done_w) begin
            nw_done++;
            done_w_cyc = cyc_w;
         end
         prev_w = !cen_w;
      end
   end

   task automatic start_run();
      q.delete();
      for (int n = 0; n < 64; n++) q.push_back(model(n, 2));
      cyc = 0; n_iss = 0; n_valid = 0; n_done = 0; last_iss = 0; done_cyc = 0;
      run_len = 0; max_run = 0; prev_iss = 0;
      sb_on = 1;
      @(posedge clk); #1 start = 1; ready = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic wait_iss(input int k);
      for (int c = 0; c < 300 && n_iss < k; c++) begin
         @(posedge clk); #1;
      end
      check("reach_beat_count", n_iss, k);
   endtask

   task automatic finish_run(input int exp_max);
      for (int c = 0; c < 400 && n_done == 0; c++) begin
         @(posedge clk); #1;
      end
      check("done_seen", int'(n_done != 0), 1);
      check("busy_low_after_drain", int'(busy), 0);
      repeat (5) @(posedge clk);
      #1;
      check("issued_beats", n_iss, 64);
      check("valid_cycles", n_valid, 64);
      check("done_pulses", n_done, 1);
      check("done_after_last_beat", done_cyc, last_iss + 1);
      check("scoreboard_empty", q.size(), 0);
      if (exp_max > 0) check("consecutive_cen_low", max_run, exp_max);
      sb_on = 0;
   endtask

   initial begin
      vec_t vec[9];
      vec[0] = '{0, 0, 1, o(1, 0, 0, 0, 0, 1, 0)};
      vec[1] = '{1, 1, 1, o(1, 0, 0, 0, 0, 1, 0)};
      vec[2] = '{1, 0, 1, o(0, 1, 0, 0, 0, 1, 0)};
      vec[3] = '{0, 0, 1, o(0, 1, 0, 1, 0, 1, 1)};
      vec[4] = '{0, 0, 0, o(1, 1, 0, 0, 0, 1, 1)};
      vec[5] = '{0, 0, 1, o(0, 1, 0, 1, 0, 1, 2)};
      vec[6] = '{0, 1, 1, o(1, 0, 0, 1, 0, 1, 0)};
      vec[7] = '{0, 0, 1, o(1, 0, 0, 0, 0, 1, 0)};
      vec[8] = '{0, 1, 0, o(1, 0, 0, 0, 0, 1, 0)};
      #12 check("reset_values", int'(cur()), int'(o(1, 0, 0, 0, 0, 1, 0)));
      check("reset_values_wrap", int'({cen_w, busy_w, done_w, valid_w, sc_w, idx_w, beat_w}),
            int'(o(1, 0, 0, 0, 0, 1, 0)));
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 9; i++) begin
         start = vec[i].start; abort = vec[i].abort; ready = vec[i].ready;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vector_%0d", i), int'(cur()), int'(vec[i].exp));
      end
      start = 0; abort = 0; ready = 1;
      // basic run
      start_run();
      finish_run(64);
      // five-cycle stall in front of beat 7 of group 0
      start_run();
      wait_iss(7);
      ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_hold", int'({cen, tf_idx, beat}), int'({1'b1, 6'd1, 4'd7}));
         @(posedge clk); #1;
      end
      ready = 1;
      finish_run(-1);
      // abort after 20 beats, then a clean run
      start_run();
      wait_iss(20);
      abort = 1;
      @(posedge clk); #1 abort = 0;
      check("abort_state", int'(cur()), int'(o(1, 0, 0, 1, 0, 1, 0)));
      repeat (80) @(posedge clk);
      #1;
      check("no_done_after_abort", n_done, 0);
      check("idle_after_abort", int'(busy), 0);
      start_run();
      finish_run(64);
      // start pulses during RUN and DRAIN are ignored
      start_run();
      wait_iss(30);
      start = 1;
      @(posedge clk); #1 start = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(posedge clk); #1;
      end
      start = 1;
      @(posedge clk); #1 start = 0;
      finish_run(64);
      // asynchronous reset in stage 1
      start_run();
      wait_iss(40);
      sb_on = 0;
      #1 rst_n = 0;
      #1 check("async_reset_mid_run", int'(cur()), int'(o(1, 0, 0, 0, 0, 1, 0)));
      @(negedge clk) rst_n = 1;
      begin
         bit saw_done = 0;
         repeat (10) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
         end
         check("quiet_after_reset", int'(saw_done), 0);
      end
      // single stage with 64 groups: index wraps 63 -> 0
      qw.delete();
      for (int n = 0; n < 1024; n++) qw.push_back(model(n, 64));
      sbw_on = 1;
      @(posedge clk); #1 start_w = 1;
      @(posedge clk); #1 start_w = 0;
      for (int c = 0; c < 1500 && nw_done == 0; c++) begin
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check("wrap_issued_beats", nw_iss, 1024);
      check("wrap_done_pulses", nw_done, 1);
      check("wrap_done_after_last", done_w_cyc, last_w + 1);
      check("wrap_scoreboard_empty", qw.size(), 0);
      sbw_on = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
